vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Pixel-source stage between the sync controller and the painter in the VGA pipeline.
- Consumes the horizontal/vertical counters and video-enable from the sync controller.
- Produces a registered 24-bit RGB pixel for the painter.
- A debounced "swap" push-button steps through four test patterns; pattern changes take effect only at a frame boundary, so no frame tears.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- DEBOUNCE_CYCLES, 250000, consecutive stable pixel-clock cycles needed to accept a button level change (10 ms at 25 MHz).
- BAR_WIDTH, 80, pixel width of each colour bar (H_ACTIVE/8).

Ports:
- clk  input  1  pixel clock (divided clock).
- reset  input  1  synchronous, active-high reset.
- swap  input  1  active-high button request, already inverted at top level; asynchronous and bouncy.
- hCounter  input  10  current pixel column from the sync controller.
- vCounter  input  10  current line from the sync controller.
- vidOn  input  1  high while (hCounter, vCounter) is in the visible area.
- color  output  24  {R[23:16], G[15:8], B[7:0]}, registered.
- pattern  output  2  currently displayed pattern index (debug/LED).

Behaviour:
- Reset: one clk cycle with reset=1 clears all state.
  - color=0, pattern=0, frame_cnt=0, pending=0.
  - Debouncer state = RELEASED, debounce counter = 0.
  - Synchronizer flops = 0.
- Input sync: swap goes through a 2-flop synchronizer before the debouncer, adding 2 cycles of latency.
- Debouncer FSM, states RELEASED and PRESSED:
  - The counter increments while the synced input differs from the state's level, and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the FSM toggles state and the counter clears.
  - RELEASED->PRESSED generates a single one-cycle press pulse. PRESSED->RELEASED generates no pulse.
  - Holding the button gives exactly one pulse. A glitch shorter than DEBOUNCE_CYCLES gives no pulse.
- Pending request:
  - A press pulse sets pending.
  - Multiple presses within one frame collapse to a single pending request.
- Frame boundary: the cycle where hCounter==0 and vCounter==V_ACTIVE (first blanking line). On that cycle:
  - frame_cnt increments, 8-bit, wrapping 255->0.
  - If pending=1: pattern increments modulo 4 (3->0) and pending clears.
  - A press pulse on the same cycle as a boundary sets pending for the next boundary; it does not advance the pattern on this boundary.
- Pixel generation: combinational from (pattern, hCounter, vCounter, frame_cnt), registered into color with 1-cycle latency.
  - If vidOn=0 in cycle N, color=0 in cycle N+1, overriding every pattern.
  - Pattern 0, colour bars: index i = hCounter/BAR_WIDTH, computed by comparators with no divider; indices at or above 7 saturate to 7.
    - Colours by index 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Pattern 1, checkerboard: (hCounter[5] XOR vCounter[5]) ? FFFFFF : 000000, giving 32-px squares.
  - Pattern 2, grey ramp: R=G=B=hCounter[9:2], i.e. 0..159 across the line.
  - Pattern 3, animated solid: R=frame_cnt, G=~frame_cnt, B=8'h80.
- pattern output changes only on a frame-boundary cycle (or reset). It is registered and visible the cycle after the boundary.
- Reset mid-frame or mid-debounce:
  - Returns to pattern 0 and discards any pending request.
  - A button still held through reset must first be debounced as pressed, giving a new pulse after DEBOUNCE_CYCLES+2 cycles.
- Counter inputs beyond the visible area are ignored whenever vidOn=0; no range checking otherwise.

Test Plan (bench overrides DEBOUNCE_CYCLES=8):
- Reset; drive hCounter=0, vCounter=0, vidOn=1, pattern 0 -> next cycle color=FFFFFF. At hCounter=85 -> FFFF00. At hCounter=639 -> 000000. pattern=0.
- Pattern 0, vidOn=0 with hCounter=100 -> color=000000 one cycle later.
- swap pulses high for 5 cycles, then low -> no press pulse; at the next boundary (h=0, v=480) pattern stays 0.
- swap held high 40 cycles, then released -> exactly one pulse. pattern becomes 1 the cycle after the next boundary. Then h=32, v=0 -> FFFFFF; h=32, v=32 -> 000000.
- Three debounced presses within one frame -> pattern advances by exactly 1 at the boundary. A press coincident with the boundary cycle -> advance deferred to the following boundary.
- Advance to pattern 3, run 256 frame boundaries -> color at (0,0) cycles R=00..FF and wraps to 00 with G=~R, B=80. Assert reset mid-line -> color=0 and pattern=0 on the next cycle.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: a debounced swap button selects one of four patterns,
// applied only at frame boundaries; the pixel colour is registered for the painter.
module vga_pattern_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BAR_WIDTH       = H_ACTIVE / 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        swap,
    input  logic [9:0]  hCounter,
    input  logic [9:0]  vCounter,
    input  logic        vidOn,
    output logic [23:0] color,
    output logic [1:0]  pattern
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic RELEASED = 1'b0;
    localparam logic PRESSED  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [9:0]       V_BOUNDARY = 10'(V_ACTIVE);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic [1:0]       pattern_q, pattern_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [23:0]      color_q, color_d;
    logic             press_s;
    logic             boundary_s;
    logic [2:0]       bar_idx_s;
    logic [23:0]      pixel_s;

    // Synchronizer and debouncer; the state value doubles as the accepted button level.
    always_comb begin
        sync1_d = swap;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        press_s = 1'b0;
        if (sync2_q != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ~state_q;
                cnt_d   = {CNT_W{1'b0}};
                press_s = (state_q == RELEASED);
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Frame-boundary bookkeeping; a press on the boundary itself waits for the next one.
    always_comb begin
        boundary_s  = (hCounter == 10'd0) && (vCounter == V_BOUNDARY);
        pattern_d   = pattern_q;
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        if (boundary_s) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (pending_q) begin
                pattern_d = pattern_q + 2'd1;
                pending_d = 1'b0;
            end else begin
                pending_d = pending_q;
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        if (press_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_d;
        end
    end

    // Colour-bar index from threshold comparators, saturating at the last bar.
    always_comb begin
        bar_idx_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({1'b0, hCounter} >= 11'(k * BAR_WIDTH)) begin
                bar_idx_s = 3'(k);
            end else begin
                bar_idx_s = bar_idx_s;
            end
        end
    end

    // Pattern pixel selection, blanked outside the visible area.
    always_comb begin
        pixel_s = 24'h000000;
        case (pattern_q)
            2'd0: begin
                case (bar_idx_s)
                    3'd0:    pixel_s = 24'hFFFFFF;
                    3'd1:    pixel_s = 24'hFFFF00;
                    3'd2:    pixel_s = 24'h00FFFF;
                    3'd3:    pixel_s = 24'h00FF00;
                    3'd4:    pixel_s = 24'hFF00FF;
                    3'd5:    pixel_s = 24'hFF0000;
                    3'd6:    pixel_s = 24'h0000FF;
                    default: pixel_s = 24'h000000;
                endcase
            end
            2'd1:    pixel_s = (hCounter[5] ^ vCounter[5]) ? 24'hFFFFFF : 24'h000000;
            2'd2:    pixel_s = {hCounter[9:2], hCounter[9:2], hCounter[9:2]};
            2'd3:    pixel_s = {frame_cnt_q, ~frame_cnt_q, 8'h80};
            default: pixel_s = 24'h000000;
        endcase
        if (vidOn) begin
            color_d = pixel_s;
        end else begin
            color_d = 24'h000000;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= RELEASED;
            cnt_q       <= {CNT_W{1'b0}};
            pending_q   <= 1'b0;
            pattern_q   <= 2'd0;
            frame_cnt_q <= 8'd0;
            color_q     <= 24'h000000;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            pattern_q   <= pattern_d;
            frame_cnt_q <= frame_cnt_d;
            color_q     <= color_d;
        end
    end

    assign color   = color_q;
    assign pattern = pattern_q;

    logic unused_pressed_s;
    assign unused_pressed_s = (state_q == PRESSED);

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: directed steps with randomized pixel
// positions, checked every cycle against a behavioural model of the pattern source.
module tb_vga_pattern_gen;

    localparam int DEB      = 8;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int BAR      = 80;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        swap = 1'b0;
    logic [9:0]  h = 10'd0;
    logic [9:0]  v = 10'd0;
    logic        vid = 1'b0;
    logic [23:0] color;
    logic [1:0]  pattern;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .DEBOUNCE_CYCLES(DEB), .BAR_WIDTH(BAR)
    ) dut (
        .clk(clk), .reset(reset), .swap(swap), .hCounter(h), .vCounter(v),
        .vidOn(vid), .color(color), .pattern(pattern)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic        m_d1, m_d2, m_level, m_pend;
    int          m_run;
    logic [1:0]  m_pat;
    logic [7:0]  m_fc;
    logic [23:0] m_color;

    function automatic logic [23:0] ref_pixel(input logic [1:0] pat, input int hh, input int vv,
                                              input logic [7:0] fc);
        int idx;
        logic [7:0] g;
        case (pat)
            2'd0: begin
                idx = hh / BAR;
                if (idx > 7) idx = 7;
                case (idx)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2'd1: return (((hh / 32) % 2) != ((vv / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
            2'd2: begin
                g = 8'(hh / 4);
                return {g, g, g};
            end
            default: return {fc, 8'(255 - int'(fc)), 8'h80};
        endcase
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict from current inputs, advance, then compare outputs.
    task automatic step();
        logic synced, press;
        logic [23:0] nc;
        logic [1:0] np;
        logic npend;
        logic [7:0] nfc;
        if (reset) begin
            m_d1 = 1'b0; m_d2 = 1'b0; m_level = 1'b0; m_run = 0;
            np = 2'd0; npend = 1'b0; nfc = 8'd0; nc = 24'h000000;
        end else begin
            synced = m_d2;
            press  = 1'b0;
            if (synced != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = synced;
                    m_run   = 0;
                    press   = synced;
                end
            end else begin
                m_run = 0;
            end
            nc    = vid ? ref_pixel(m_pat, int'(h), int'(v), m_fc) : 24'h000000;
            np    = m_pat;
            npend = m_pend;
            nfc   = m_fc;
            if (h == 10'd0 && v == 10'(V_ACTIVE)) begin
                nfc = m_fc + 8'd1;
                if (m_pend) begin
                    np    = m_pat + 2'd1;
                    npend = 1'b0;
                end
            end
            if (press) npend = 1'b1;
            m_d2 = m_d1;
            m_d1 = swap;
        end
        @(posedge clk);
        #1;
        m_pat = np; m_pend = npend; m_fc = nfc; m_color = nc;
        check("color", color, m_color);
        check("pattern", {22'd0, pattern}, {22'd0, m_pat});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            h   = 10'($urandom_range(1, H_ACTIVE - 1));
            v   = 10'($urandom_range(0, V_ACTIVE - 1));
            vid = 1'b1;
            step();
        end
    endtask

    task automatic boundary();
        h = 10'd0; v = 10'(V_ACTIVE); vid = 1'b0;
        step();
    endtask

    task automatic at(input int hh, input int vv);
        h = 10'(hh); v = 10'(vv); vid = 1'b1;
        step();
    endtask

    initial begin
        reset = 1'b1;
        step();
        check("reset_color", color, 24'h000000);
        check("reset_pattern", {22'd0, pattern}, 24'd0);
        reset = 1'b0;

        at(0, 0);   check("bar0", color, 24'hFFFFFF);
        at(85, 0);  check("bar1", color, 24'hFFFF00);
        at(639, 0); check("bar7", color, 24'h000000);
        check("pat0", {22'd0, pattern}, 24'd0);
        h = 10'd100; v = 10'd10; vid = 1'b0; step();
        check("blank", color, 24'h000000);

        for (int i = 0; i < 24; i++) begin
            h   = 10'($urandom_range(0, 1023));
            v   = 10'($urandom_range(0, V_ACTIVE - 1));
            vid = 1'($urandom_range(0, 1));
            if (h == 10'd0) h = 10'd1;
            step();
        end

        // Glitch shorter than the debounce window.
        swap = 1'b1; idle($urandom_range(1, 5));
        swap = 1'b0; idle(14);
        boundary(); idle(2);
        check("glitch_pat", {22'd0, pattern}, 24'd0);

        // Long hold gives one press.
        swap = 1'b1; idle(40);
        swap = 1'b0; idle(14);
        boundary();
        check("hold_pat", {22'd0, pattern}, 24'd1);
        at(32, 0);  check("chk_w", color, 24'hFFFFFF);
        at(32, 32); check("chk_b", color, 24'h000000);
        for (int i = 0; i < 16; i++) at($urandom_range(0, H_ACTIVE - 1), $urandom_range(0, V_ACTIVE - 1));

        // Three presses collapse into one advance.
        for (int i = 0; i < 3; i++) begin
            swap = 1'b1; idle(12);
            swap = 1'b0; idle(12);
        end
        boundary();
        check("multi_pat", {22'd0, pattern}, 24'd2);
        for (int i = 0; i < 16; i++) at($urandom_range(0, H_ACTIVE - 1), $urandom_range(0, V_ACTIVE - 1));

        // Press pulse lands on the boundary cycle: deferred.
        swap = 1'b1; idle(9);
        boundary();
        check("coinc_pat", {22'd0, pattern}, 24'd2);
        swap = 1'b0; idle(14);
        boundary();
        check("defer_pat", {22'd0, pattern}, 24'd3);

        // Animated solid across a full frame-counter wrap.
        for (int i = 0; i < 257; i++) begin
            at(0, 0);
            if (i < 3) idle(1);
            boundary();
        end
        at(0, 0);

        // Reset mid-line with the button held.
        h = 10'd300; v = 10'd100; vid = 1'b1; swap = 1'b1;
        reset = 1'b1; step();
        check("rst_color", color, 24'h000000);
        check("rst_pattern", {22'd0, pattern}, 24'd0);
        reset = 1'b0;
        idle(14);
        swap = 1'b0; idle(14);
        boundary();
        check("rst_repress", {22'd0, pattern}, 24'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
